// File: rtl/sin_rom_arbiter.sv
// Two-channel read arbiter in front of a shared fixed-latency sine ROM, one read in flight.
// Define SINARB_FIXED_PRIO_EN for fixed channel-0 priority instead of round-robin.
`timescale 1ns/1ps
module sin_rom_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  localparam int unsigned      CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_dec;
  logic                r_win;
  logic                w_win_nxt;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                w_gnt0_nxt;
  logic                w_gnt1_nxt;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic                w_rvalid0_nxt;
  logic                w_rvalid1_nxt;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic [DATA_W-1:0]   w_rdata0_nxt;
  logic [DATA_W-1:0]   w_rdata1_nxt;
  logic                r_rom_ce;
  logic                w_rom_ce_nxt;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic [ADDR_W-1:0]   w_rom_addr_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                w_any_req;
  logic                w_pick;

  assign w_any_req = req0 | req1;

`ifdef SINARB_FIXED_PRIO_EN
  // Channel 1 wins only when channel 0 is not requesting.
  assign w_pick = ~req0;
`else
  logic r_last;
  logic w_last_nxt;

  // Under contention the channel not granted last wins; a lone request always wins.
  assign w_pick = (req0 & req1) ? ~r_last : req1;

  always_comb begin
    w_last_nxt = r_last;
    if ((r_state == IDLE) && w_any_req) begin
      w_last_nxt = w_pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else begin
      r_last <= w_last_nxt;
    end
  end
`endif

  assign w_cnt_dec = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : '0;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_win_nxt      = r_win;
    w_gnt0_nxt     = 1'b0;
    w_gnt1_nxt     = 1'b0;
    w_rvalid0_nxt  = 1'b0;
    w_rvalid1_nxt  = 1'b0;
    w_rdata0_nxt   = r_rdata0;
    w_rdata1_nxt   = r_rdata1;
    w_rom_ce_nxt   = 1'b0;
    w_rom_addr_nxt = r_rom_addr;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = ISSUE;
          w_win_nxt      = w_pick;
          w_rom_addr_nxt = w_pick ? addr1 : addr0;
          w_gnt0_nxt     = ~w_pick;
          w_gnt1_nxt     = w_pick;
          w_rom_ce_nxt   = 1'b1;
        end
      end
      ISSUE: begin
        if (ROM_LAT <= 1) begin
          w_state_nxt = CAPTURE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: begin
        w_cnt_nxt = w_cnt_dec;
        if (w_cnt_dec == '0) begin
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        w_state_nxt = IDLE;
        if (r_win) begin
          w_rdata1_nxt  = rom_data;
          w_rvalid1_nxt = 1'b1;
        end else begin
          w_rdata0_nxt  = rom_data;
          w_rvalid0_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers; reset discards any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_win      <= 1'b0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_rom_ce   <= 1'b0;
      r_rom_addr <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_win      <= w_win_nxt;
      r_gnt0     <= w_gnt0_nxt;
      r_gnt1     <= w_gnt1_nxt;
      r_rvalid0  <= w_rvalid0_nxt;
      r_rvalid1  <= w_rvalid1_nxt;
      r_rdata0   <= w_rdata0_nxt;
      r_rdata1   <= w_rdata1_nxt;
      r_rom_ce   <= w_rom_ce_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign gnt0     = r_gnt0;
  assign gnt1     = r_gnt1;
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign rom_ce   = r_rom_ce;
  assign rom_addr = r_rom_addr;
  assign busy     = r_busy;

endmodule

// File: doc/sin_rom_arbiter.md
SIN_ROM_ARBITER -- requirements
Module: sin_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, ROM address width.
REQ-002 Parameter DATA_W, default 16, ROM sample width.
REQ-003 Parameter ROM_LAT, default 2, cycles from the ROM read-issue cycle to valid rom_data; legal range 1..7.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 req0 / req1  input  1  read request, channel 0 / 1; held high until the matching gnt.
REQ-007 addr0 / addr1  input  ADDR_W  read address, channel 0 / 1; stable while req is high.
REQ-008 gnt0 / gnt1  output  1  one-cycle pulse: request accepted, address captured.
REQ-009 rvalid0 / rvalid1  output  1  one-cycle pulse: rdata valid for that channel.
REQ-010 rdata0 / rdata1  output  DATA_W  returned sample; holds its value until the next rvalid for that channel.
REQ-011 rom_ce  output  1  ROM read enable to the shared sine table.
REQ-012 rom_addr  output  ADDR_W  ROM address.
REQ-013 rom_data  input  DATA_W  ROM read data.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM has states IDLE, ISSUE, WAIT and CAPTURE.
REQ-016 Only one read is outstanding at any time.
REQ-017 IDLE with req0 or req1 high -> ISSUE at the next edge.
REQ-018 On that edge, the winner's addr is registered into rom_addr and the winner's gnt pulses for the ISSUE cycle.
REQ-019 IDLE with no request -> stays in IDLE.
REQ-020 In ISSUE, rom_ce = 1 for exactly one cycle.
REQ-021 ISSUE -> WAIT, loading the wait counter with ROM_LAT-1.
REQ-022 WAIT decrements the counter and -> CAPTURE when the counter reaches 0.
REQ-023 With ROM_LAT=1, ISSUE -> CAPTURE directly.
REQ-024 In CAPTURE, rom_data is registered into the winner's rdata and the FSM -> IDLE.
REQ-025 The winner's rvalid is high in the first IDLE cycle after CAPTURE.
REQ-026 A new request may be accepted in that same IDLE cycle (back-to-back operation).
REQ-027 Latency: req sampled in IDLE cycle N -> gnt and rom_ce in cycle N+1 -> rvalid in cycle N+ROM_LAT+2.
REQ-028 Throughput: one read every ROM_LAT+2 cycles.
REQ-029 Arbitration is round-robin; a 1-bit last-grant pointer updates on every grant.
REQ-030 When both requests are high in IDLE, the channel not granted last wins.
REQ-031 When only one request is high, that channel wins regardless of the pointer.
REQ-032 A losing request stays pending, with no gnt, until a later IDLE cycle.
REQ-033 rom_addr holds its value outside ISSUE; rom_ce is 0 outside ISSUE.
REQ-034 gnt0 and gnt1 are never high together; rvalid0 and rvalid1 are never high together.
REQ-035 A request that drops before its gnt is silently withdrawn, with no gnt and no rvalid.
REQ-036 All arithmetic is unsigned; the wait counter is 3 bits and never wraps.

Reset
REQ-037 While rst is high: FSM = IDLE; gnt*, rvalid*, rom_ce, busy = 0; rdata* and rom_addr = 0; wait counter = 0; last-grant pointer = 1, so channel 0 wins the first contention.
REQ-038 Reset asserted mid-read discards the in-flight read; no rvalid is generated for it after reset is released.
REQ-039 The first request can be accepted in the first cycle after rst deasserts.

Configuration
REQ-040 With SINARB_FIXED_PRIO_EN defined, channel 0 always wins contention, the last-grant pointer is not implemented, and channel 1 is served only when req0 is low in IDLE.
REQ-041 Without SINARB_FIXED_PRIO_EN defined, round-robin arbitration per REQ-029..REQ-032 applies.
REQ-042 All other behaviour is identical with or without SINARB_FIXED_PRIO_EN.

Verification
REQ-043 Single read, ROM_LAT=2: req0 with addr0=0x40 held in IDLE at cycle 10 -> gnt0 and rom_ce high at cycle 11 with rom_addr=0x40; rvalid0 high at cycle 14 with rdata0 = ROM[0x40].
REQ-044 Contention after reset: req0 and req1 both high continuously -> grants go ch0, ch1, ch0, ch1, one every 4 cycles; the fixed-priority build gives ch0 on every grant.
REQ-045 Back-to-back: req1 held high with addr1 stepping 0..255 on each gnt1 -> 256 rvalid1 pulses, one every 4 cycles, with data matching the table and the address wrapping from 255 to 0.
REQ-046 Reset during read: rst pulsed in the WAIT state -> outputs zero, no rvalid afterwards, next req0 served normally with correct data.
REQ-047 ROM_LAT=1 and ROM_LAT=7: single reads -> rvalid at N+3 and N+9 respectively, and busy high for exactly ROM_LAT+1 cycles.
